ahb_wr_stream: RTL and testbench
================================

// Module: ahb_wr_stream
// PURPOSE
//  Upstream feeder for ahb_master's user interface (UI). Buffers write data from a
//  producer in an internal FIFO and sequences one write command (base address, size,
//  beat count) onto the UI. Obeys the o_next rule: after the first beat, UI outputs
//  change only on an edge where i_next=1. Replaces ad-hoc FIFO/UI glue in benches and SoC.
// PARAMETERS
//  DATA_WDT    32  data width; matches ahb_master DATA_WDT
//  BEAT_WDT    32  beat-count width; matches ahb_master BEAT_WDT
//  FIFO_DEPTH  16  FIFO entries; power of 2, >=2
// PORTS
//  i_hclk       in   1             clock; all logic on posedge
//  i_hreset_n   in   1             async active-low reset
//  i_push       in   1             producer write strobe
//  i_push_data  in   DATA_WDT      producer data
//  o_full       out  1             FIFO full; push ignored while 1
//  o_level      out  $clog2(D)+1   FIFO occupancy
//  o_ovf        out  1             sticky: push seen while full; cleared by accepted i_start
//  i_start      in   1             command strobe, honoured in IDLE only
//  i_base_addr  in   32            burst base address
//  i_size       in   3             beat size (hsize encoding)
//  i_len        in   BEAT_WDT      total beats in command
//  o_busy       out  1             command in progress
//  o_done       out  1             1-cycle pulse, command complete
//  i_next       in   1             ahb_master o_next
//  o_data       out  DATA_WDT      to ahb_master i_data
//  o_dav        out  1             to i_dav
//  o_addr       out  32            to i_addr (latched base, constant per command)
//  o_size       out  3             to i_size (latched)
//  o_wr         out  1             to i_wr
//  o_rd         out  1             to i_rd; constant 0
//  o_min_len    out  BEAT_WDT      to i_min_len (latched i_len)
//  o_cont       out  1             to i_cont
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO flushed; state IDLE; counters 0. Reset mid-command
//    abandons it silently (no o_done).
//  - FIFO: 1 push/1 pop per cycle. Simultaneous push+pop when full: push dropped, sets o_ovf.
//    Pop only at UI load (below); never pops when empty.
//  - States: IDLE -> ARM -> STREAM -> IDLE.
//  - IDLE: i_start with i_len!=0: latch addr/size/len to o_addr/o_size/o_min_len.
//    Clear issued/accepted counters and o_ovf. Go ARM; o_busy=1 next cycle.
//    i_start with i_len=0: o_done pulses next cycle, no UI activity.
//  - ARM: wait for !empty. Then pop and load o_data=head with o_dav=1, o_wr=1, o_cont=0,
//    issued=1; go STREAM. First UI beat therefore always has valid data.
//  - STREAM: outputs held unless i_next=1. On edge with i_next=1:
//    * if o_dav=1, accepted++ (beat consumed);
//    * if accepted (after increment) == len: o_wr=0, o_cont=0, o_dav=0, o_busy=0,
//      o_done=1 for one cycle, go IDLE;
//    * else o_cont=1; if issued<len and FIFO !empty: pop, o_data=head, o_dav=1, issued++;
//      else o_dav=0, o_data held (don't-care).
//  - Empty FIFO mid-burst gives o_dav=0 gaps, never a stall of o_next handling.
//  - Push into empty FIFO lands same edge; visible to a load on the following edge.
//  - i_start outside IDLE ignored. Counters BEAT_WDT wide; len up to 2^BEAT_WDT-1.
//  - o_busy=1 from ARM through the o_done edge.
// STRUCTURE
//  - ahb_stream_pkg: state enum (IDLE, ARM, STREAM); hsize constants (BYTE/HALF/WORD).
//  - Sub-module ahb_sync_fifo #(DATA_WDT, FIFO_DEPTH): sync FIFO, FWFT read port
//    (head visible when !empty), level/full/empty outputs, async active-low reset.
//  - Top: FSM, issued/accepted counters, UI output registers.
// TESTING (bench: ahb_wr_stream -> ahb_master -> ahb_slave_sim, random o_next-driven flow)
//  1. Prefill 4 words, start len=4, addr=0x100, size=WORD -> beat1 cont=0, then 3 cont=1 beats
//     1,2,3,4 on slave; o_done once; o_level=0.
//  2. Start len=8 with empty FIFO, push 1 word every 5 cycles -> UI stays o_wr=0 until first
//     push; o_dav=0 gaps between; slave sees 8 in-order words.
//  3. Push 17 words into depth-16 FIFO with no command -> o_full=1, o_level=16, o_ovf=1;
//     next i_start clears o_ovf.
//  4. Assert i_start with i_len=0 -> o_done pulses 1 cycle later; o_wr never rises.
//  5. Start len=100, drop i_hreset_n after 30 accepted beats -> all outputs 0 same cycle,
//     FIFO empty, no o_done; fresh len=2 command afterwards completes.
//  6. Hold i_next=0 for 10 cycles mid-burst -> o_data/o_dav/o_cont unchanged throughout.

Source files
------------

// File: rtl/ahb_stream_pkg.sv
// ahb_stream_pkg: shared constants for the AHB write-stream feeder.
//   State encodings for the command sequencer (IDLE -> ARM -> STREAM)
//   and hsize encodings used when building commands.
package ahb_stream_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;
endpackage

// File: rtl/ahb_sync_fifo.sv
// ahb_sync_fifo: single-clock FIFO with first-word-fall-through read port.
//   i_hclk/i_hreset_n : clock, async active-low reset (flushes pointers/level)
//   i_push/i_push_data: write strobe and data; ignored while o_full
//   i_pop             : consume head; ignored while o_empty
//   o_head            : current head entry, valid whenever !o_empty
//   o_empty/o_full/o_level : occupancy status
module ahb_sync_fifo #(
    parameter int DATA_WDT   = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_hclk,
    input  logic                          i_hreset_n,
    input  logic                          i_push,
    input  logic [DATA_WDT-1:0]           i_push_data,
    input  logic                          i_pop,
    output logic [DATA_WDT-1:0]           o_head,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_WDT-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         level_q;
    logic                push_ok, pop_ok;
    // A push while full is dropped even if a pop happens on the same edge.
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_empty = level_q == '0;
    assign o_full  = level_q == (AW+1)'(FIFO_DEPTH);
    assign o_level = level_q;
    assign o_head  = mem_q[rd_ptr_q];
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
            level_q  <= level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge i_hclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
    end
endmodule

// File: rtl/ahb_wr_stream.sv
// ahb_wr_stream: buffers producer words and sequences one write command onto the ahb_master UI.
//   Producer side : i_push/i_push_data in; o_full, o_level, o_ovf (sticky overflow) out
//   Command side  : i_start/i_base_addr/i_size/i_len in; o_busy, o_done (1-cycle) out
//   UI side       : i_next in; o_data/o_dav/o_addr/o_size/o_wr/o_rd/o_min_len/o_cont out
//   After the first beat, UI outputs only change on an edge where i_next=1.
module ahb_wr_stream
    import ahb_stream_pkg::*;
#(
    parameter int DATA_WDT   = 32,
    parameter int BEAT_WDT   = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_hclk,
    input  logic                          i_hreset_n,
    input  logic                          i_push,
    input  logic [DATA_WDT-1:0]           i_push_data,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_ovf,
    input  logic                          i_start,
    input  logic [31:0]                   i_base_addr,
    input  logic [2:0]                    i_size,
    input  logic [BEAT_WDT-1:0]           i_len,
    output logic                          o_busy,
    output logic                          o_done,
    input  logic                          i_next,
    output logic [DATA_WDT-1:0]           o_data,
    output logic                          o_dav,
    output logic [31:0]                   o_addr,
    output logic [2:0]                    o_size,
    output logic                          o_wr,
    output logic                          o_rd,
    output logic [BEAT_WDT-1:0]           o_min_len,
    output logic                          o_cont
);
    logic [1:0]          state_q, state_d;
    logic [BEAT_WDT-1:0] issued_q, issued_d, accepted_q, accepted_d, len_q, len_d, acc_inc;
    logic [31:0]         addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_WDT-1:0] data_q, data_d, head;
    logic                dav_q, dav_d, wr_q, wr_d, cont_q, cont_d;
    logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic                pop, empty, full;
    ahb_sync_fifo #(.DATA_WDT(DATA_WDT), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .i_hclk      (i_hclk),
        .i_hreset_n  (i_hreset_n),
        .i_push      (i_push),
        .i_push_data (i_push_data),
        .i_pop       (pop),
        .o_head      (head),
        .o_empty     (empty),
        .o_full      (full),
        .o_level     (o_level)
    );
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        len_d      = len_q;
        addr_d     = addr_q;
        size_d     = size_q;
        data_d     = data_q;
        dav_d      = dav_q;
        wr_d       = wr_q;
        cont_d     = cont_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        // A beat is only consumed when the presented beat carried data.
        acc_inc    = accepted_q + BEAT_WDT'(dav_q);
        ovf_d      = ovf_q | (i_push & full);
        case (state_q)
            ST_IDLE: if (i_start) begin
                ovf_d = i_push & full;
                if (i_len != '0) begin
                    addr_d     = i_base_addr;
                    size_d     = i_size;
                    len_d      = i_len;
                    issued_d   = '0;
                    accepted_d = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_ARM;
                end else begin
                    done_d = 1'b1;
                end
            end
            // The first beat is held back until data exists, so it is never a gap.
            ST_ARM: if (!empty) begin
                pop      = 1'b1;
                data_d   = head;
                dav_d    = 1'b1;
                wr_d     = 1'b1;
                cont_d   = 1'b0;
                issued_d = BEAT_WDT'(1);
                state_d  = ST_STREAM;
            end
            ST_STREAM: if (i_next) begin
                accepted_d = acc_inc;
                if (acc_inc == len_q) begin
                    wr_d    = 1'b0;
                    cont_d  = 1'b0;
                    dav_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cont_d = 1'b1;
                    if (issued_q < len_q && !empty) begin
                        pop      = 1'b1;
                        data_d   = head;
                        dav_d    = 1'b1;
                        issued_d = issued_q + BEAT_WDT'(1);
                    end else begin
                        dav_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q    <= ST_IDLE;
            issued_q   <= '0;
            accepted_q <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            data_q     <= '0;
            dav_q      <= 1'b0;
            wr_q       <= 1'b0;
            cont_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            data_q     <= data_d;
            dav_q      <= dav_d;
            wr_q       <= wr_d;
            cont_q     <= cont_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end
    assign o_full    = full;
    assign o_ovf     = ovf_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_data    = data_q;
    assign o_dav     = dav_q;
    assign o_addr    = addr_q;
    assign o_size    = size_q;
    assign o_wr      = wr_q;
    assign o_rd      = 1'b0;
    assign o_min_len = len_q;
    assign o_cont    = cont_q;
endmodule

// File: tb/tb_ahb_wr_stream.sv
// tb_ahb_wr_stream: scoreboard bench for ahb_wr_stream with a pattern-driven i_next consumer.
module tb_ahb_wr_stream;
    import ahb_stream_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_push, i_start, i_next;
    logic [31:0] i_push_data, i_base_addr, i_len;
    logic [2:0]  i_size;
    logic        o_full, o_ovf, o_busy, o_done, o_dav, o_wr, o_rd, o_cont;
    logic [4:0]  o_level;
    logic [31:0] o_data, o_addr, o_min_len;
    logic [2:0]  o_size;
    int          vectors = 0, errors = 0;
    int          done_cnt = 0, exp_done = 0, consumed = 0, gaps = 0;
    logic [31:0] exp_q[$];
    bit          first = 1'b1, hold = 1'b0;
    logic [15:0] next_pat = 16'b1101_1011_1110_0111;
    logic [3:0]  pat_idx = '0;

    ahb_wr_stream #(.DATA_WDT(32), .BEAT_WDT(32), .FIFO_DEPTH(16)) dut (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_push(i_push), .i_push_data(i_push_data),
        .o_full(o_full), .o_level(o_level), .o_ovf(o_ovf), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_size(i_size), .i_len(i_len), .o_busy(o_busy),
        .o_done(o_done), .i_next(i_next), .o_data(o_data), .o_dav(o_dav), .o_addr(o_addr),
        .o_size(o_size), .o_wr(o_wr), .o_rd(o_rd), .o_min_len(o_min_len), .o_cont(o_cont)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        i_next = hold ? 1'b0 : next_pat[pat_idx];
        pat_idx = pat_idx + 4'd1;
    end

    // Monitor: a beat is consumed on a posedge where o_wr, o_dav and i_next are all 1.
    always @(negedge clk) begin
        logic [31:0] exp;
        #2;
        if (o_done) done_cnt++;
        if (!o_wr) begin
            first = 1'b1;
            consumed = 0;
        end else if (!o_dav) begin
            gaps++;
        end else if (i_next) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_data: got %0h, expected no beat", o_data);
            end else begin
                exp = exp_q.pop_front();
                if (o_data !== exp) begin
                    errors++;
                    $display("FAIL beat_data: got %0h, expected %0h", o_data, exp);
                end
            end
            vectors++;
            if (o_cont !== !first) begin
                errors++;
                $display("FAIL beat_cont: got %0b, expected %0b", o_cont, !first);
            end
            first = 1'b0;
            consumed++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input bit expect_it);
        @(negedge clk);
        i_push = 1'b1;
        i_push_data = d;
        if (expect_it) exp_q.push_back(d);
        @(negedge clk);
        i_push = 1'b0;
    endtask

    task automatic start_cmd(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] len);
        @(negedge clk);
        i_start = 1'b1;
        i_base_addr = addr;
        i_size = size;
        i_len = len;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        exp_done++;
        while (done_cnt < exp_done && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("done_count", 128'(done_cnt), 128'(exp_done));
    endtask

    task automatic wait_consumed(input int target, input int budget);
        int n = 0;
        while (consumed < target && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        vectors++;
        if (consumed < target) begin
            errors++;
            $display("FAIL consumed_timeout: got %0d, expected %0d", consumed, target);
        end
    endtask

    initial begin
        logic [31:0] snap_data;
        logic        snap_dav, snap_cont;
        int          pushed, n;
        rst_n = 1'b0;
        i_push = 1'b0;
        i_start = 1'b0;
        i_push_data = '0;
        i_base_addr = '0;
        i_size = '0;
        i_len = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {o_full, o_level, o_ovf, o_busy, o_done, o_data, o_dav, o_addr,
            o_size, o_wr, o_rd, o_min_len, o_cont}, '0);
        rst_n = 1'b1;

        // 1: prefilled 4-beat command
        for (int i = 1; i <= 4; i++) push_word(32'(i), 1'b1);
        chk("t1_level_pre", 128'(o_level), 128'd4);
        start_cmd(32'h100, HSIZE_WORD, 32'd4);
        #3;
        chk("t1_latched", {o_addr, o_size, o_min_len, o_busy, o_rd}, {32'h100, HSIZE_WORD, 32'd4, 1'b1, 1'b0});
        wait_done(200);
        chk("t1_after", {o_level, o_busy, o_wr, 8'(exp_q.size())}, '0);

        // 2: empty FIFO, slow producer
        gaps = 0;
        start_cmd(32'h200, HSIZE_WORD, 32'd8);
        repeat (6) @(negedge clk);
        #3;
        chk("t2_wait_no_wr", {o_wr, o_busy}, {1'b0, 1'b1});
        for (int i = 0; i < 8; i++) begin
            push_word(32'hA0 + 32'(i), 1'b1);
            repeat (3) @(negedge clk);
        end
        wait_done(400);
        vectors++;
        if (gaps == 0) begin
            errors++;
            $display("FAIL t2_gaps: got %0d, expected nonzero", gaps);
        end
        chk("t2_after", {o_level, 8'(exp_q.size())}, '0);

        // 3: overflow with no command, then a start clears it
        for (int i = 0; i < 17; i++) push_word(32'h300 + 32'(i), i < 16);
        #3;
        chk("t3_full_level_ovf", {o_full, o_level, o_ovf}, {1'b1, 5'd16, 1'b1});
        start_cmd(32'h300, HSIZE_WORD, 32'd16);
        #3;
        chk("t3_ovf_cleared", 128'(o_ovf), 128'd0);
        wait_done(400);
        chk("t3_after", {o_level, 8'(exp_q.size())}, '0);

        // 4: zero-length command
        start_cmd(32'h400, HSIZE_WORD, 32'd0);
        #3;
        chk("t4_done_pulse", {o_done, o_wr, o_busy}, {1'b1, 1'b0, 1'b0});
        exp_done++;
        @(negedge clk);
        #3;
        chk("t4_done_low", {o_done, o_wr}, '0);

        // 5: reset in the middle of a long command
        start_cmd(32'h500, HSIZE_WORD, 32'd100);
        pushed = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (consumed >= 30 || n >= 2000) break;
            i_push = !o_full && pushed < 100;
            i_push_data = 32'h5000 + 32'(pushed);
            if (i_push) begin
                exp_q.push_back(i_push_data);
                pushed++;
            end
            n++;
        end
        i_push = 1'b0;
        chk("t5_reached_30", 128'(consumed >= 30), 128'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs", {o_full, o_level, o_ovf, o_busy, o_done, o_data, o_dav, o_addr,
            o_size, o_wr, o_rd, o_min_len, o_cont}, '0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("t5_no_done", 128'(done_cnt), 128'(exp_done));
        push_word(32'hBEEF0001, 1'b1);
        push_word(32'hBEEF0002, 1'b1);
        start_cmd(32'h600, HSIZE_HALF, 32'd2);
        wait_done(200);

        // 6: i_next held low mid-burst
        for (int i = 0; i < 6; i++) push_word(32'hC0 + 32'(i), 1'b1);
        start_cmd(32'h700, HSIZE_WORD, 32'd6);
        wait_consumed(2, 200);
        hold = 1'b1;
        @(negedge clk);
        #3;
        snap_data = o_data;
        snap_dav = o_dav;
        snap_cont = o_cont;
        chk("t6_mid_burst", {o_wr, o_cont}, {1'b1, 1'b1});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            chk("t6_hold", {o_data, o_dav, o_cont}, {snap_data, snap_dav, snap_cont});
        end
        hold = 1'b0;
        wait_done(200);
        chk("t6_after", {o_level, o_busy, 8'(exp_q.size())}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
